bcd_countdown_timer: RTL and testbench
======================================

Name: bcd_countdown_timer

Overview:
- Parametrised multi-digit BCD countdown timer with programmable preset, start/pause/resume/clear control, optional auto-reload and a timed beep output.
- Sits between the clock divider, which supplies a one-cycle `tick` at the count rate, and the seven-segment driver and buzzer logic.
- Counting advances only on `tick`. All control is sampled on `clock_1`.

Parameters:
- DIGITS, 2: number of BCD digits; count width is 4*DIGITS.
- RESET_VALUE, 'h15: preset and count value after reset. Width is 4*DIGITS, BCD-encoded.
- AUTO_RELOAD, 0: 1 = on reaching zero, reload the preset and keep running; 0 = stop in EXPIRED.
- BEEP_CYCLES, 8: number of `clock_1` cycles `beep` stays high after expiry. 0 = hold until cleared.

Ports:
- clock_1  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- tick  in  1  count-enable pulse, one cycle wide
- load  in  1  capture `load_value` into both the preset and the count
- load_value  in  4*DIGITS  BCD preset
- start  in  1  start or resume counting
- pause  in  1  suspend counting
- clear  in  1  restore the count from the preset and return to IDLE
- time_bcd  out  4*DIGITS  current count; digit k is bits [4k+3:4k], digit 0 is least significant
- running  out  1  high in RUN
- expired  out  1  high in EXPIRED
- done  out  1  one-cycle pulse when the count reaches zero
- beep  out  1  buzzer drive

Behaviour:
- Reset is asynchronous, active-low, on signal `reset`; the clock is `clock_1`.
  - Reset values: state=IDLE, preset=RESET_VALUE, time_bcd=RESET_VALUE, running=0, expired=0, done=0, beep=0, beep counter=0.
  - Reset mid-count aborts the count immediately, with no done pulse.
- States are IDLE, RUN, PAUSED and EXPIRED. All outputs are registered.
- Control priority within a cycle: clear > load > start > pause > tick.
- clear (any state): time_bcd <= preset, state <= IDLE, beep <= 0.
- load:
  - Accepted in IDLE, PAUSED and EXPIRED; ignored in RUN.
  - preset <= time_bcd <= sanitised load_value, state <= IDLE, beep <= 0.
  - Sanitising: any digit greater than 9 is clamped to 9.
- start:
  - From IDLE or PAUSED: state <= RUN. If time_bcd==0 at that moment, go straight to expiry handling on the same edge.
  - From EXPIRED: time_bcd <= preset, state <= RUN.
  - In RUN: ignored.
- pause: RUN -> PAUSED. Ignored in every other state. A tick in the same cycle is not counted.
- Count step (RUN, tick=1, no higher-priority control):
  - Borrow-chained BCD decrement.
  - A digit at 0 becomes 9 and borrows from the next digit; otherwise the digit decrements by 1.
  - Example: 'h20 -> 'h19; 'h100 -> 'h099 (DIGITS=3).
- Expiry, when the decrement produces zero (old value 1 in the least significant digit with all higher digits 0):
  - time_bcd <= 0 and done=1 for exactly one cycle.
  - AUTO_RELOAD=1: stay in RUN. The next tick loads the preset instead of decrementing, so the zero value is visible for one tick period. beep is not asserted.
  - AUTO_RELOAD=0: state <= EXPIRED, beep <= 1, beep counter <= BEEP_CYCLES.
- beep timing:
  - In EXPIRED with BEEP_CYCLES>0, the counter decrements every clock_1 cycle and beep drops when it reaches 0. beep is therefore high for exactly BEEP_CYCLES cycles.
  - With BEEP_CYCLES=0, beep stays high until clear, load or start.
- preset==0 with start, or AUTO_RELOAD reloading a zero preset:
  - Expires on the same edge, with done pulsed once.
  - With AUTO_RELOAD=1, done pulses on every tick.
- Ticks in IDLE, PAUSED and EXPIRED are ignored.
- Output mapping: running = (state==RUN); expired = (state==EXPIRED).
- Latency: an edge that samples tick=1 updates time_bcd on that edge, with no pipeline delay.

Test Plan:
- Reset with DIGITS=2, then start and 15 ticks -> time_bcd goes 15,14,...,10,09,...,01,00. done pulses once on the 15th tick, expired=1, beep high for 8 cycles then low.
- load 'h3A -> preset and time_bcd read 'h39. Start, 10 ticks -> 'h29 (checks the 'h30 -> 'h29 borrow).
- Start from 'h15, 3 ticks, pause, 5 ticks, start, 2 ticks -> time_bcd 'h12 during pause, then 'h10. running toggles 1->0->1.
- AUTO_RELOAD=1, preset 'h02, start, 6 ticks -> time_bcd 01,00,02,01,00,02. done pulses after ticks 2 and 5, beep stays 0.
- Reset asserted asynchronously mid-edge while at 'h07 in RUN -> outputs return immediately to 'h15, IDLE, beep=0, with no done pulse.
- clear and load asserted together in EXPIRED with BEEP_CYCLES=0 -> clear wins: time_bcd=preset, IDLE, beep drops. A load issued while in RUN is ignored.

Source files
------------

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer with programmable preset, start/pause/clear control,
// optional auto-reload on reaching zero and a timed beep after expiry.
module bcd_countdown_timer #(
  parameter int unsigned         DIGITS      = 2,
  parameter logic [4*DIGITS-1:0] RESET_VALUE = 'h15,
  parameter bit                  AUTO_RELOAD = 1'b0,
  parameter int unsigned         BEEP_CYCLES = 8
) (
  input  logic                clock_1,
  input  logic                reset,
  input  logic                tick,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_value,
  input  logic                start,
  input  logic                pause,
  input  logic                clear,
  output logic [4*DIGITS-1:0] time_bcd,
  output logic                running,
  output logic                expired,
  output logic                done,
  output logic                beep
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES + 1) : 1;
  localparam logic [CW-1:0] BEEP_INIT = CW'(BEEP_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSED, ST_EXPIRED} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    preset_q, preset_d;
  logic [W-1:0]    time_q, time_d;
  logic            running_q, running_d;
  logic            expired_q, expired_d;
  logic            done_q, done_d;
  logic            beep_q, beep_d;
  logic [CW-1:0]   beep_cnt_q, beep_cnt_d;
  logic [W-1:0]    start_val;
  logic            expire;

  // Digits above 9 are clamped to 9 so the count is always valid BCD.
  function automatic logic [W-1:0] sanitise(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int k = 0; k < DIGITS; k++)
      if (v[4*k +: 4] > 4'd9) r[4*k +: 4] = 4'd9;
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (borrow) begin
        if (v[4*k +: 4] == 4'd0) begin
          r[4*k +: 4] = 4'd9;
        end else begin
          r[4*k +: 4] = v[4*k +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    preset_d   = preset_q;
    time_d     = time_q;
    done_d     = 1'b0;
    beep_d     = beep_q;
    beep_cnt_d = beep_cnt_q;
    start_val  = time_q;
    expire     = 1'b0;

    // Timed beep: counter runs down in EXPIRED, beep drops as it hits zero.
    if (state_q == ST_EXPIRED && BEEP_CYCLES != 0 && beep_cnt_q != '0) begin
      beep_cnt_d = beep_cnt_q - CW'(1);
      beep_d     = (beep_cnt_q != CW'(1));
    end

    if (clear) begin
      time_d     = preset_q;
      state_d    = ST_IDLE;
      beep_d     = 1'b0;
      beep_cnt_d = '0;
    end else if (load && state_q != ST_RUN) begin
      preset_d   = sanitise(load_value);
      time_d     = sanitise(load_value);
      state_d    = ST_IDLE;
      beep_d     = 1'b0;
      beep_cnt_d = '0;
    end else if (start && state_q != ST_RUN) begin
      start_val  = (state_q == ST_EXPIRED) ? preset_q : time_q;
      time_d     = start_val;
      state_d    = ST_RUN;
      beep_d     = 1'b0;
      beep_cnt_d = '0;
      expire     = (start_val == '0);
    end else if (pause && state_q == ST_RUN) begin
      state_d = ST_PAUSED;
    end else if (tick && state_q == ST_RUN) begin
      // A zero count in RUN only exists under auto-reload: this tick restores the preset.
      if (time_q == '0) begin
        time_d = preset_q;
        expire = (preset_q == '0);
      end else begin
        time_d = bcd_dec(time_q);
        expire = (time_d == '0);
      end
    end

    if (expire) begin
      time_d = '0;
      done_d = 1'b1;
      if (!AUTO_RELOAD) begin
        state_d    = ST_EXPIRED;
        beep_d     = 1'b1;
        beep_cnt_d = BEEP_INIT;
      end
    end

    running_d = (state_d == ST_RUN);
    expired_d = (state_d == ST_EXPIRED);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock_1 or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      preset_q   <= RESET_VALUE;
      time_q     <= RESET_VALUE;
      running_q  <= 1'b0;
      expired_q  <= 1'b0;
      done_q     <= 1'b0;
      beep_q     <= 1'b0;
      beep_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      preset_q   <= preset_d;
      time_q     <= time_d;
      running_q  <= running_d;
      expired_q  <= expired_d;
      done_q     <= done_d;
      beep_q     <= beep_d;
      beep_cnt_q <= beep_cnt_d;
    end
  end

  assign time_bcd = time_q;
  assign running  = running_q;
  assign expired  = expired_q;
  assign done     = done_q;
  assign beep     = beep_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer: three configurations (plain, auto-reload,
// three digits with held beep), expected outputs queued with each stimulus cycle.
module tb_bcd_countdown_timer;
  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_TK   = 5'b00001;
  localparam logic [4:0] C_PS   = 5'b00010;
  localparam logic [4:0] C_ST   = 5'b00100;
  localparam logic [4:0] C_LD   = 5'b01000;
  localparam logic [4:0] C_CL   = 5'b10000;

  typedef struct {
    string       tag;
    int          d;
    logic [15:0] want;
  } sb_t;

  logic        clock_1;
  logic        reset;
  logic        tick_v[3], load_v[3], start_v[3], pause_v[3], clear_v[3];
  logic [11:0] lv_v[3];

  logic [7:0]  t0, t1;
  logic [11:0] t2;
  logic        run0, exp0, done0, beep0;
  logic        run1, exp1, done1, beep1;
  logic        run2, exp2, done2, beep2;

  sb_t sb_q[$];
  int  n_total = 0;
  int  n_bad   = 0;

  bcd_countdown_timer #(.DIGITS(2), .RESET_VALUE(8'h15), .AUTO_RELOAD(1'b0), .BEEP_CYCLES(8)) u_dut0 (
    .clock_1(clock_1), .reset(reset), .tick(tick_v[0]), .load(load_v[0]),
    .load_value(lv_v[0][7:0]), .start(start_v[0]), .pause(pause_v[0]), .clear(clear_v[0]),
    .time_bcd(t0), .running(run0), .expired(exp0), .done(done0), .beep(beep0)
  );

  bcd_countdown_timer #(.DIGITS(2), .RESET_VALUE(8'h15), .AUTO_RELOAD(1'b1), .BEEP_CYCLES(8)) u_dut1 (
    .clock_1(clock_1), .reset(reset), .tick(tick_v[1]), .load(load_v[1]),
    .load_value(lv_v[1][7:0]), .start(start_v[1]), .pause(pause_v[1]), .clear(clear_v[1]),
    .time_bcd(t1), .running(run1), .expired(exp1), .done(done1), .beep(beep1)
  );

  bcd_countdown_timer #(.DIGITS(3), .RESET_VALUE(12'h100), .AUTO_RELOAD(1'b0), .BEEP_CYCLES(0)) u_dut2 (
    .clock_1(clock_1), .reset(reset), .tick(tick_v[2]), .load(load_v[2]),
    .load_value(lv_v[2]), .start(start_v[2]), .pause(pause_v[2]), .clear(clear_v[2]),
    .time_bcd(t2), .running(run2), .expired(exp2), .done(done2), .beep(beep2)
  );

  initial clock_1 = 1'b0;
  always #5 clock_1 = ~clock_1;

  function automatic logic [11:0] bcd(input int v);
    return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] ex(input logic [11:0] t, input logic r, input logic x,
                                     input logic dn, input logic b);
    return {b, dn, x, r, t};
  endfunction

  function automatic logic [15:0] obs(input int d);
    case (d)
      0:       return {beep0, done0, exp0, run0, 4'h0, t0};
      1:       return {beep1, done1, exp1, run1, 4'h0, t1};
      default: return {beep2, done2, exp2, run2, t2};
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h ({beep,done,expired,running,time})", tag, got, want);
    end
  endtask

  task automatic pop_check();
    sb_t e;
    if (sb_q.size() == 0) begin
      n_total++;
      n_bad++;
      $display("FAIL sb_empty: got=0 entries want>=1");
    end else begin
      e = sb_q.pop_front();
      check(e.tag, obs(e.d), e.want);
    end
  endtask

  // One clock of stimulus on DUT d; the expectation is queued now and compared after the edge.
  task automatic cyc(input int d, input logic [4:0] ctl, input logic [11:0] lv,
                     input logic [15:0] want, input string tag);
    {clear_v[d], load_v[d], start_v[d], pause_v[d], tick_v[d]} = ctl;
    lv_v[d] = lv;
    sb_q.push_back('{tag, d, want});
    @(posedge clock_1);
    #1;
    {clear_v[d], load_v[d], start_v[d], pause_v[d], tick_v[d]} = 5'b0;
    pop_check();
  endtask

  initial begin
    int seq1[6] = '{1, 0, 2, 1, 0, 2};
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      {clear_v[i], load_v[i], start_v[i], pause_v[i], tick_v[i]} = 5'b0;
      lv_v[i] = '0;
    end
    repeat (2) @(posedge clock_1);
    #1 reset = 1'b1;

    cyc(0, C_NONE, 0, ex(12'h015, 0, 0, 0, 0), "rst0");
    cyc(1, C_NONE, 0, ex(12'h015, 0, 0, 0, 0), "rst1");
    cyc(2, C_NONE, 0, ex(12'h100, 0, 0, 0, 0), "rst2");

    // Full countdown from 15, expiry, 8-cycle beep.
    cyc(0, C_ST, 0, ex(12'h015, 1, 0, 0, 0), "t1_start");
    for (int i = 1; i <= 15; i++)
      cyc(0, C_TK, 0, ex(bcd(15 - i), (i != 15), (i == 15), (i == 15), (i == 15)),
          $sformatf("t1_tick%0d", i));
    for (int k = 1; k <= 8; k++)
      cyc(0, C_NONE, 0, ex(12'h000, 0, 1, 0, (k < 8)), $sformatf("t1_beep%0d", k));
    cyc(0, C_TK, 0, ex(12'h000, 0, 1, 0, 0), "t1_tick_expired");

    // Sanitised load and the 30 -> 29 borrow; load in RUN ignored.
    cyc(0, C_LD, 12'h03A, ex(12'h039, 0, 0, 0, 0), "t2_load3A");
    cyc(0, C_ST, 0, ex(12'h039, 1, 0, 0, 0), "t2_start");
    for (int i = 1; i <= 10; i++)
      cyc(0, C_TK, 0, ex(bcd(39 - i), 1, 0, 0, 0), $sformatf("t2_tick%0d", i));
    cyc(0, C_LD, 12'h055, ex(12'h029, 1, 0, 0, 0), "t2_load_in_run");
    cyc(0, C_CL, 0, ex(12'h039, 0, 0, 0, 0), "t2_clear");

    // Pause / resume.
    cyc(0, C_LD, 12'h015, ex(12'h015, 0, 0, 0, 0), "t3_load15");
    cyc(0, C_ST, 0, ex(12'h015, 1, 0, 0, 0), "t3_start");
    for (int i = 1; i <= 3; i++)
      cyc(0, C_TK, 0, ex(bcd(15 - i), 1, 0, 0, 0), $sformatf("t3_tick%0d", i));
    cyc(0, C_PS | C_TK, 0, ex(12'h012, 0, 0, 0, 0), "t3_pause_tick");
    for (int i = 1; i <= 5; i++)
      cyc(0, C_TK, 0, ex(12'h012, 0, 0, 0, 0), $sformatf("t3_paused_tick%0d", i));
    cyc(0, C_ST, 0, ex(12'h012, 1, 0, 0, 0), "t3_resume");
    cyc(0, C_TK, 0, ex(12'h011, 1, 0, 0, 0), "t3_tick_a");
    cyc(0, C_TK, 0, ex(12'h010, 1, 0, 0, 0), "t3_tick_b");

    // Asynchronous reset while running at 07.
    for (int i = 1; i <= 3; i++)
      cyc(0, C_TK, 0, ex(bcd(10 - i), 1, 0, 0, 0), $sformatf("t4_tick%0d", i));
    tick_v[0] = 1'b1;
    #2 reset = 1'b0;
    #1;
    sb_q.push_back('{"t4_async_rst", 0, ex(12'h015, 0, 0, 0, 0)});
    pop_check();
    sb_q.push_back('{"t4_rst_edge", 0, ex(12'h015, 0, 0, 0, 0)});
    @(posedge clock_1);
    #1;
    pop_check();
    tick_v[0] = 1'b0;
    reset = 1'b1;
    cyc(0, C_NONE, 0, ex(12'h015, 0, 0, 0, 0), "t4_after_rst");

    // Zero preset with start expires on the same edge.
    cyc(0, C_LD, 12'h000, ex(12'h000, 0, 0, 0, 0), "t5_load0");
    cyc(0, C_ST, 0, ex(12'h000, 0, 1, 1, 1), "t5_start0");
    cyc(0, C_NONE, 0, ex(12'h000, 0, 1, 0, 1), "t5_hold");

    // Auto-reload with preset 02, then a zero preset.
    cyc(1, C_LD, 12'h002, ex(12'h002, 0, 0, 0, 0), "t6_load02");
    cyc(1, C_ST, 0, ex(12'h002, 1, 0, 0, 0), "t6_start");
    for (int i = 0; i < 6; i++)
      cyc(1, C_TK, 0, ex(bcd(seq1[i]), 1, 0, (seq1[i] == 0), 0), $sformatf("t6_tick%0d", i + 1));
    cyc(1, C_PS, 0, ex(12'h002, 0, 0, 0, 0), "t6_pause");
    cyc(1, C_LD, 12'h000, ex(12'h000, 0, 0, 0, 0), "t6_load0");
    cyc(1, C_ST, 0, ex(12'h000, 1, 0, 1, 0), "t6_start0");
    cyc(1, C_NONE, 0, ex(12'h000, 1, 0, 0, 0), "t6_idle0");
    cyc(1, C_TK, 0, ex(12'h000, 1, 0, 1, 0), "t6_tick0a");
    cyc(1, C_TK, 0, ex(12'h000, 1, 0, 1, 0), "t6_tick0b");

    // Three digits, held beep, clear beats load.
    cyc(2, C_ST, 0, ex(12'h100, 1, 0, 0, 0), "t7_start");
    cyc(2, C_TK, 0, ex(12'h099, 1, 0, 0, 0), "t7_tick100");
    cyc(2, C_TK, 0, ex(12'h098, 1, 0, 0, 0), "t7_tick099");
    cyc(2, C_LD, 12'h001, ex(12'h098, 1, 0, 0, 0), "t7_load_in_run");
    cyc(2, C_PS, 0, ex(12'h098, 0, 0, 0, 0), "t7_pause");
    cyc(2, C_TK, 0, ex(12'h098, 0, 0, 0, 0), "t7_paused_tick");
    cyc(2, C_LD, 12'hAF5, ex(12'h995, 0, 0, 0, 0), "t7_sanitise");
    cyc(2, C_LD, 12'h001, ex(12'h001, 0, 0, 0, 0), "t7_load001");
    cyc(2, C_ST, 0, ex(12'h001, 1, 0, 0, 0), "t7_start001");
    cyc(2, C_TK, 0, ex(12'h000, 0, 1, 1, 1), "t7_expire");
    for (int k = 1; k <= 10; k++)
      cyc(2, C_NONE, 0, ex(12'h000, 0, 1, 0, 1), $sformatf("t7_beep_hold%0d", k));
    cyc(2, C_ST, 0, ex(12'h001, 1, 0, 0, 0), "t7_restart");
    cyc(2, C_TK, 0, ex(12'h000, 0, 1, 1, 1), "t7_expire2");
    cyc(2, C_NONE, 0, ex(12'h000, 0, 1, 0, 1), "t7_hold2");
    cyc(2, C_CL | C_LD, 12'h050, ex(12'h001, 0, 0, 0, 0), "t7_clear_load");
    cyc(2, C_ST, 0, ex(12'h001, 1, 0, 0, 0), "t7_preset_kept");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
